// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter that shares one 8-bit memory port between icache fetch, LSB load and LSB store.
// Optional fetch fairness (a fetch wins right after a load/store grant) is built when MEM_ARB_FAIR_EN is defined.
module mem_arbiter #(
  parameter int BLK_BYTES = 16,
  parameter int LSB_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_aout,
  output logic                   mem_rw,
  input  logic                   io_buffer_full,
  input  logic                   if_req,
  input  logic [31:0]            if_addr,
  output logic                   if_done,
  output logic [BLK_BYTES*8-1:0] if_blk,
  input  logic                   ld_req,
  input  logic [31:0]            ld_addr,
  input  logic [2:0]             ld_type,
  input  logic [LSB_WIDTH-1:0]   ld_id,
  output logic                   ld_done,
  output logic [LSB_WIDTH-1:0]   ld_id_out,
  output logic [31:0]            ld_val,
  input  logic                   st_req,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_val,
  input  logic [2:0]             st_type,
  output logic                   st_done,
  output logic                   busy
);

  localparam int BLK_W = BLK_BYTES * 8;
  localparam int CNT_W = $clog2(BLK_BYTES) + 2;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  function automatic logic [CNT_W-1:0] xfer_len(input logic [1:0] f3);
    case (f3)
      2'b00:   return CNT_W'(1);
      2'b01:   return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [7:0] store_byte(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, len;
  logic [31:0]          base, wdata;
  logic [2:0]           ftype;
  logic [LSB_WIDTH-1:0] id_lat;
  logic [BLK_W-1:0]     line_buf, line_buf_nxt;
  logic                 if_done_r, ld_done_r, st_done_r;
  logic                 st_io, st_ok, ld_ok, if_ok, fair_pick;
  logic                 gnt_if, gnt_ld, gnt_st, fin;
  logic                 unused_ok;

  assign unused_ok = st_type[2];

  // A requester still holds req during its own done cycle, so that cycle is masked.
  assign st_io = (st_addr[17:16] == 2'b11);
  assign st_ok = st_req && !st_done_r && !(st_io && io_buffer_full);
  assign ld_ok = ld_req && !ld_done_r && !flush_in;
  assign if_ok = if_req && !if_done_r && !flush_in;

`ifdef MEM_ARB_FAIR_EN
  logic fair;
  assign fair_pick = fair && if_ok;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      fair <= 1'b0;
    end else if (rdy_in) begin
      if (gnt_ld || gnt_st) fair <= 1'b1;
      else if (gnt_if)      fair <= 1'b0;
    end
  end
`else
  assign fair_pick = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_if    = 1'b0;
    gnt_ld    = 1'b0;
    gnt_st    = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fair_pick)  gnt_if = 1'b1;
        else if (st_ok) gnt_st = 1'b1;
        else if (ld_ok) gnt_ld = 1'b1;
        else if (if_ok) gnt_if = 1'b1;
        if (gnt_st)      state_nxt = STORE;
        else if (gnt_ld) state_nxt = LOAD;
        else if (gnt_if) state_nxt = FETCH;
      end
      FETCH, LOAD: begin
        // Reads run one cycle longer than addressing because mem_din lags the address.
        if (flush_in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == len) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          fin       = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STORE: begin
        if (cnt == len - CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          fin       = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_aout = '0;
    mem_dout = '0;
    mem_rw   = 1'b0;
    case (state)
      FETCH, LOAD: begin
        if (cnt < len) mem_aout = base + 32'(cnt);
      end
      STORE: begin
        mem_aout = base + 32'(cnt);
        mem_dout = store_byte(wdata, cnt[1:0]);
        mem_rw   = rdy_in;
      end
      default: ;
    endcase
  end

  // Byte addressed at count c-1 arrives while the count reads c.
  always_comb begin
    line_buf_nxt = line_buf;
    for (int i = 0; i < BLK_BYTES; i++) begin
      if (cnt == CNT_W'(i + 1)) line_buf_nxt[i*8 +: 8] = mem_din;
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cnt       <= '0;
      len       <= '0;
      base      <= '0;
      wdata     <= '0;
      ftype     <= '0;
      id_lat    <= '0;
      line_buf  <= '0;
      if_blk    <= '0;
      ld_val    <= '0;
      ld_id_out <= '0;
      if_done_r <= 1'b0;
      ld_done_r <= 1'b0;
      st_done_r <= 1'b0;
    end else if (rdy_in) begin
      cnt       <= cnt_nxt;
      if_done_r <= 1'b0;
      ld_done_r <= 1'b0;
      st_done_r <= 1'b0;
      if (gnt_if) begin
        base <= if_addr;
        len  <= CNT_W'(BLK_BYTES);
      end
      if (gnt_ld) begin
        base   <= ld_addr;
        len    <= xfer_len(ld_type[1:0]);
        ftype  <= ld_type;
        id_lat <= ld_id;
      end
      if (gnt_st) begin
        base  <= st_addr;
        len   <= xfer_len(st_type[1:0]);
        wdata <= st_val;
      end
      if (state == FETCH || state == LOAD) line_buf <= line_buf_nxt;
      if (fin) begin
        case (state)
          FETCH: begin
            if_blk    <= line_buf_nxt;
            if_done_r <= 1'b1;
          end
          LOAD: begin
            ld_val    <= load_extend(line_buf_nxt[31:0], ftype);
            ld_id_out <= id_lat;
            ld_done_r <= 1'b1;
          end
          STORE:   st_done_r <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // A done pulse frozen by rdy_in=0 is shown on the first enabled cycle.
  assign if_done = if_done_r && rdy_in;
  assign ld_done = ld_done_r && rdy_in;
  assign st_done = st_done_r && rdy_in;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte memory model, expected queues for loads, fetches and writes.
module tb_mem_arbiter;
  localparam int BLK_BYTES = 16;
  localparam int LSB_WIDTH = 4;
  localparam int BLK_W = BLK_BYTES * 8;

  logic clk, rst_in, rdy_in, flush_in;
  logic [7:0] mem_din, mem_dout;
  logic [31:0] mem_aout;
  logic mem_rw, io_buffer_full;
  logic if_req, if_done;
  logic [31:0] if_addr;
  logic [BLK_W-1:0] if_blk;
  logic ld_req, ld_done;
  logic [31:0] ld_addr, ld_val;
  logic [2:0] ld_type;
  logic [LSB_WIDTH-1:0] ld_id, ld_id_out;
  logic st_req, st_done, busy;
  logic [31:0] st_addr, st_val;
  logic [2:0] st_type;

  mem_arbiter #(.BLK_BYTES(BLK_BYTES), .LSB_WIDTH(LSB_WIDTH)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_aout(mem_aout), .mem_rw(mem_rw),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_blk(if_blk),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_type(ld_type), .ld_id(ld_id),
    .ld_done(ld_done), .ld_id_out(ld_id_out), .ld_val(ld_val),
    .st_req(st_req), .st_addr(st_addr), .st_val(st_val), .st_type(st_type),
    .st_done(st_done), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int if_done_cnt = 0;

  logic [7:0] mem [logic [31:0]];
  logic [31:0] ld_val_q[$];
  logic [LSB_WIDTH-1:0] ld_id_q[$];
  logic [BLK_W-1:0] if_q[$];
  logic [39:0] wr_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Synchronous byte memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    mem_din <= rd(mem_aout);
    if (mem_rw) mem[mem_aout] = mem_dout;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_in) begin
      if (ld_done) begin
        if (ld_val_q.size() == 0) chk("ld_unexp", ld_done, 1'b0);
        else begin
          chk("ld_val", ld_val, ld_val_q.pop_front());
          chk("ld_id", ld_id_out, ld_id_q.pop_front());
        end
      end
      if (if_done) begin
        if_done_cnt++;
        if (if_q.size() == 0) chk("if_unexp", if_done, 1'b0);
        else chk("if_blk", if_blk, if_q.pop_front());
      end
      if (mem_rw) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("wr_unexp", mem_rw, 1'b0);
        else chk("wr_addr_data", {mem_aout, mem_dout}, wr_q.pop_front());
      end
    end
  end

  task automatic wait_done(input int which, input int lim, output int dcyc);
    logic timed_out;
    dcyc = -1;
    for (int i = 0; i < lim && dcyc < 0; i++) begin
      @(negedge clk);
      if ((which == 0 && ld_done) || (which == 1 && if_done) || (which == 2 && st_done))
        dcyc = cyc;
    end
    timed_out = (dcyc < 0);
    chk($sformatf("done_wait_%0d", which), timed_out, 1'b0);
  endtask

  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [LSB_WIDTH-1:0] id,
                          input logic [31:0] exp, input int lat);
    int t0, d;
    ld_val_q.push_back(exp);
    ld_id_q.push_back(id);
    ld_addr = a; ld_type = f3; ld_id = id; ld_req = 1'b1;
    t0 = cyc;
    wait_done(0, 60, d);
    ld_req = 1'b0;
    if (d >= 0) chk("ld_lat", d - t0, lat);
    @(negedge clk);
  endtask

  task automatic push_writes(input logic [31:0] a, input logic [31:0] v, input int n);
    for (int k = 0; k < n; k++) wr_q.push_back({a + 32'(k), 8'(v >> (8 * k))});
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] v, input logic [2:0] f3, input int lat);
    int t0, d;
    push_writes(a, v, (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4);
    st_addr = a; st_val = v; st_type = f3; st_req = 1'b1;
    t0 = cyc;
    wait_done(2, 60, d);
    st_req = 1'b0;
    if (d >= 0) chk("st_lat", d - t0, lat);
    @(negedge clk);
  endtask

  initial begin
    int t0, d1, d2, w0, f0;
    logic [BLK_W-1:0] line;
    logic any_rw;
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; ld_req = 1'b0; ld_addr = '0; ld_type = '0; ld_id = '0;
    st_req = 1'b0; st_addr = '0; st_val = '0; st_type = '0;
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h84;
    for (int i = 0; i < BLK_BYTES; i++) begin
      mem[32'h1000 + 32'(i)] = 8'(8'hA0 + i);
      line[i*8 +: 8] = 8'(8'hA0 + i);
    end
    #23;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rw", mem_rw, 1'b0);
    chk("rst_aout", mem_aout, 32'h0);
    chk("rst_dones", {if_done, ld_done, st_done}, 3'b000);
    chk("rst_ldval", ld_val, 32'h0);
    chk("rst_ifblk", if_blk, '0);
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);

    run_load(32'h100, 3'b010, 4'd5, 32'h84332211, 6);
    run_load(32'h103, 3'b000, 4'd1, 32'hFFFFFF84, 3);
    run_load(32'h103, 3'b100, 4'd2, 32'h00000084, 3);
    run_load(32'h102, 3'b001, 4'd3, 32'hFFFF8433, 4);
    run_load(32'h102, 3'b101, 4'd4, 32'h00008433, 4);
    run_load(32'h100, 3'b001, 4'd6, 32'h00002211, 4);

    run_store(32'h200, 32'hAABBCCDD, 3'b001, 3);
    run_store(32'h300, 32'h12345678, 3'b010, 5);
    run_load(32'h300, 3'b010, 4'd7, 32'h12345678, 6);

    // fetch and load requested together: load first, fetch right after
    ld_val_q.push_back(32'h84332211); ld_id_q.push_back(4'd9); if_q.push_back(line);
    ld_addr = 32'h100; ld_type = 3'b010; ld_id = 4'd9; ld_req = 1'b1;
    if_addr = 32'h1000; if_req = 1'b1;
    t0 = cyc;
    fork
      begin wait_done(0, 60, d1); ld_req = 1'b0; end
      begin wait_done(1, 80, d2); if_req = 1'b0; end
    join
    chk("cont_ld_lat", d1 - t0, 6);
    chk("cont_if_lat", d2 - t0, 6 + BLK_BYTES + 2);
    @(negedge clk);

    // store beats load
    ld_val_q.push_back(32'h00000011); ld_id_q.push_back(4'd10);
    push_writes(32'h210, 32'h77, 1);
    st_addr = 32'h210; st_val = 32'h77; st_type = 3'b000; st_req = 1'b1;
    ld_addr = 32'h100; ld_type = 3'b000; ld_id = 4'd10; ld_req = 1'b1;
    t0 = cyc;
    fork
      begin wait_done(2, 60, d1); st_req = 1'b0; end
      begin wait_done(0, 60, d2); ld_req = 1'b0; end
    join
    chk("prio_st_lat", d1 - t0, 2);
    chk("prio_ld_lat", d2 - t0, 5);
    @(negedge clk);

    // flush aborts a fetch
    f0 = if_done_cnt;
    if_addr = 32'h1000; if_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_busy_before", busy, 1'b1);
    flush_in = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("flush_idle", busy, 1'b0);
    flush_in = 1'b0;
    repeat (25) @(negedge clk);
    chk("flush_no_done", if_done_cnt - f0, 0);

    // IO store held off while the UART buffer is full; a load gets through meanwhile
    io_buffer_full = 1'b1;
    w0 = wr_cnt;
    st_addr = 32'h30000; st_val = 32'h5A; st_type = 3'b000; st_req = 1'b1;
    any_rw = 1'b0;
    repeat (4) begin @(negedge clk); any_rw = any_rw | mem_rw; end
    chk("io_blocked_rw", any_rw, 1'b0);
    run_load(32'h103, 3'b100, 4'd11, 32'h00000084, 3);
    chk("io_blocked_wr", wr_cnt - w0, 0);
    push_writes(32'h30000, 32'h5A, 1);
    io_buffer_full = 1'b0;
    t0 = cyc;
    wait_done(2, 60, d1);
    st_req = 1'b0;
    chk("io_st_lat", d1 - t0, 2);
    chk("io_one_write", wr_cnt - w0, 1);
    chk("io_mem", rd(32'h30000), 8'h5A);
    @(negedge clk);

    // rdy_in low for three edges mid-store
    push_writes(32'h400, 32'h0A0B0C0D, 4);
    st_addr = 32'h400; st_val = 32'h0A0B0C0D; st_type = 3'b010; st_req = 1'b1;
    t0 = cyc;
    @(negedge clk);
    @(posedge clk); #1;
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rdy_rw", mem_rw, 1'b0);
    end
    @(posedge clk); #1;
    rdy_in = 1'b1;
    wait_done(2, 60, d1);
    st_req = 1'b0;
    chk("rdy_st_lat", d1 - t0, 8);
    chk("rdy_mem", {rd(32'h403), rd(32'h402), rd(32'h401), rd(32'h400)}, 32'h0A0B0C0D);
    @(negedge clk);

    // asynchronous reset mid-load
    ld_addr = 32'h100; ld_type = 3'b010; ld_id = 4'd12; ld_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_busy_before", busy, 1'b1);
    rst_in = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_aout", mem_aout, 32'h0);
    chk("arst_ldval", ld_val, 32'h0);
    chk("arst_ldid", ld_id_out, '0);
    chk("arst_ifblk", if_blk, '0);
    ld_req = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
    repeat (12) @(negedge clk);

    chk("left_wr", wr_q.size(), 0);
    chk("left_ld", ld_val_q.size(), 0);
    chk("left_if", if_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
